// File: rtl/pwm_ctrl_pkg.sv
// Shared types and duty arithmetic for the PWM sequencer blocks.
package pwm_ctrl_pkg;

    localparam int DUTY_W_DEFAULT = 4;
    localparam int CALC_W         = 16;

    typedef enum logic [1:0] {IDLE, RAMP, FINISH} state_t;
    typedef logic [DUTY_W_DEFAULT-1:0] duty_t;
    typedef logic [CALC_W-1:0]         calc_t;

    // Move cur toward tgt by stp, landing exactly on tgt instead of overshooting.
    // The sum carries an extra bit so an up-step near the top cannot wrap.
    function automatic calc_t sat_step(input calc_t cur, input calc_t tgt, input calc_t stp);
        logic [CALC_W:0] sum;
        calc_t           nxt;
        sum = {1'b0, cur} + {1'b0, stp};
        nxt = cur;
        if (tgt > cur) begin
            if (sum >= {1'b0, tgt}) nxt = tgt;
            else                    nxt = sum[CALC_W-1:0];
        end else if (tgt < cur) begin
            if ((cur - tgt) <= stp) nxt = tgt;
            else                    nxt = cur - stp;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_ramp_controller_pacer.sv
// Period pacer: counts generator period ends and flags the one that should
// carry a duty step. Loaded with the hold count when a command is accepted,
// reloaded from the latched hold after every step.
module pwm_period_pacer #(
    parameter int HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [HOLD_WIDTH-1:0] load_val,
    input  logic [HOLD_WIDTH-1:0] reload_val,
    input  logic                  period_end,
    output logic                  step_now
);

    logic [HOLD_WIDTH-1:0] hold_cnt;

    // A period end only steps once the hold count has run down to zero.
    always_comb begin
        step_now = enable && period_end && (hold_cnt == '0);
    end

    // Hold down-counter: load on accept, decrement per period, reload after a step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (load) begin
            hold_cnt <= load_val;
        end else if (enable && period_end) begin
            hold_cnt <= step_now ? reload_val : hold_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Duty ramp sequencer in front of one PWM generator. Takes a target/step/hold
// command and walks the generator duty toward the target, one strobed update
// every (hold+1) generator periods.
module pwm_ramp_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_WIDTH   = 4,
    parameter int MAX_DUTY     = 8,
    parameter int INITIAL_DUTY = 0,
    parameter int HOLD_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DUTY_WIDTH-1:0] cmd_target,
    input  logic [DUTY_WIDTH-1:0] cmd_step,
    input  logic [HOLD_WIDTH-1:0] cmd_hold,
    input  logic                  period_end,
    output logic [DUTY_WIDTH-1:0] pwm_duty_cycle,
    output logic                  update_parameters,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DUTY_WIDTH-1:0] MAX_D  = DUTY_WIDTH'(MAX_DUTY);
    localparam logic [DUTY_WIDTH-1:0] INIT_D = DUTY_WIDTH'(INITIAL_DUTY);

    state_t                state_q, state_n;
    logic [DUTY_WIDTH-1:0] tgt_q, step_q;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic [DUTY_WIDTH-1:0] tgt_in, step_in, duty_step, duty_n;
    logic                  upd_n, done_n, busy_n, rdy_n, latch, step_now;

    pwm_period_pacer #(.HOLD_WIDTH(HOLD_WIDTH)) u_pacer (
        .clk        (clk),
        .reset      (reset),
        .enable     (state_q == RAMP),
        .load       (latch),
        .load_val   (cmd_hold),
        .reload_val (hold_q),
        .period_end (period_end),
        .step_now   (step_now)
    );

    // Command sanitising and the candidate next duty for a step.
    always_comb begin
        tgt_in    = (cmd_target > MAX_D) ? MAX_D : cmd_target;
        step_in   = (cmd_step == '0) ? DUTY_WIDTH'(1) : cmd_step;
        duty_step = DUTY_WIDTH'(sat_step(calc_t'(pwm_duty_cycle), calc_t'(tgt_q), calc_t'(step_q)));
    end

    // Next state and next registered outputs. The final ramp step returns to
    // IDLE with cmd_ready still low so the done cycle cannot also accept.
    always_comb begin
        state_n = state_q;
        duty_n  = pwm_duty_cycle;
        upd_n   = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        rdy_n   = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    latch = 1'b1;
                    if (tgt_in == pwm_duty_cycle) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RAMP;
                        busy_n  = 1'b1;
                    end
                end else begin
                    rdy_n = 1'b1;
                end
            end
            RAMP: begin
                busy_n = 1'b1;
                if (step_now) begin
                    duty_n = duty_step;
                    upd_n  = 1'b1;
                    if (duty_step == tgt_q) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
            default: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Registered outputs and the latched command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_duty_cycle    <= INIT_D;
            update_parameters <= 1'b0;
            done              <= 1'b0;
            busy              <= 1'b0;
            cmd_ready         <= 1'b1;
            tgt_q             <= '0;
            step_q            <= '0;
            hold_q            <= '0;
        end else begin
            pwm_duty_cycle    <= duty_n;
            update_parameters <= upd_n;
            done              <= done_n;
            busy              <= busy_n;
            cmd_ready         <= rdy_n;
            if (latch) begin
                tgt_q  <= tgt_in;
                step_q <= step_in;
                hold_q <= cmd_hold;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: directed and random ramps against a
// list-of-duties model plus period-end counting for strobe timing.
module tb_pwm_ramp_controller;

    localparam int DW = 4, MAXD = 8, INITD = 0, HW = 8, NR = 15;

    logic          clk = 1'b0, reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [DW-1:0] cmd_target = '0, cmd_step = '0;
    logic [HW-1:0] cmd_hold = '0;
    logic          period_end = 1'b0;
    logic [DW-1:0] pwm_duty_cycle;
    logic          update_parameters, busy, done;

    int total = 0, bad = 0, cur = INITD;
    int st_cyc[$], st_duty[$], pe_edges[$];
    int done_cyc, done_cnt, dchg, rdy_early;
    bit busy0, busy_after, rdy_after, timed_out;

    pwm_ramp_controller #(.DUTY_WIDTH(DW), .MAX_DUTY(MAXD), .INITIAL_DUTY(INITD), .HOLD_WIDTH(HW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
        .period_end(period_end), .pwm_duty_cycle(pwm_duty_cycle),
        .update_parameters(update_parameters), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Offer one command (accepted at the next edge, sample index 0) and record
    // strobes, done, handshake and period_end edges until the cycle after done.
    task automatic do_ramp(input int tgt, input int step, input int hold, input bit pe_acc,
                           input bit keep, input int nt, input int ns, input int nh);
        int gap, last;
        bit fin;
        st_cyc.delete(); st_duty.delete(); pe_edges.delete();
        done_cyc = -1; done_cnt = 0; dchg = 0; rdy_early = 0;
        busy0 = 0; busy_after = 0; rdy_after = 0; fin = 0;
        last = int'(pwm_duty_cycle);
        cmd_valid = 1'b1; cmd_target = DW'(tgt); cmd_step = DW'(step); cmd_hold = HW'(hold);
        period_end = pe_acc;
        gap = $urandom_range(2, 6);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                cmd_valid = keep;
                if (keep) begin
                    cmd_target = DW'(nt); cmd_step = DW'(ns); cmd_hold = HW'(nh);
                end
            end
            if (update_parameters) begin
                st_cyc.push_back(c); st_duty.push_back(int'(pwm_duty_cycle));
            end else if (int'(pwm_duty_cycle) != last) begin
                dchg++;
            end
            last = int'(pwm_duty_cycle);
            if (c == 0) busy0 = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy; rdy_after = cmd_ready; fin = 1;
                break;
            end
            if (cmd_ready) rdy_early++;
            gap--;
            if (gap == 0) begin
                period_end = 1'b1; pe_edges.push_back(c + 1); gap = $urandom_range(2, 6);
            end else begin
                period_end = 1'b0;
            end
        end
        period_end = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (int'(pwm_duty_cycle) !== INITD) begin bad++; $display("FAIL rst_duty got=%0d want=%0d", pwm_duty_cycle, INITD); end
        total++; if (update_parameters !== 1'b0) begin bad++; $display("FAIL rst_upd got=%b want=0", update_parameters); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
        total++; if (int'(pwm_duty_cycle) !== INITD) begin bad++; $display("FAIL rst_duty2 got=%0d want=%0d", pwm_duty_cycle, INITD); end
    endtask

    // Directed rows (up, down with saturation, no-op, step 0, clamp, held
    // cmd_valid, period_end on accept) followed by random rows.
    task automatic test_ramps();
        int t[NR], s[NR], h[NR];
        bit pa[NR], kp[NR];
        int exp_d[$];
        int clamped, cs, v, idx, want_c, want_done;
        t[0] = 8;  s[0] = 2;  h[0] = 0; pa[0] = 0; kp[0] = 0;
        t[1] = 1;  s[1] = 3;  h[1] = 1; pa[1] = 1; kp[1] = 0;
        t[2] = 1;  s[2] = 5;  h[2] = 0; pa[2] = 0; kp[2] = 1;
        t[3] = 0;  s[3] = 15; h[3] = 0; pa[3] = 0; kp[3] = 0;
        t[4] = 3;  s[4] = 0;  h[4] = 0; pa[4] = 1; kp[4] = 0;
        t[5] = 15; s[5] = 1;  h[5] = 2; pa[5] = 0; kp[5] = 1;
        t[6] = 2;  s[6] = 4;  h[6] = 0; pa[6] = 1; kp[6] = 0;
        for (int i = 7; i < NR; i++) begin
            t[i] = $urandom_range(0, 15); s[i] = $urandom_range(0, 15); h[i] = $urandom_range(0, 3);
            pa[i] = 1'($urandom_range(0, 1));
            kp[i] = (i < NR - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (i < NR - 1) do_ramp(t[i], s[i], h[i], pa[i], kp[i], t[i+1], s[i+1], h[i+1]);
            else            do_ramp(t[i], s[i], h[i], pa[i], 1'b0, 0, 0, 0);
            clamped = (t[i] > MAXD) ? MAXD : t[i];
            cs = (s[i] == 0) ? 1 : s[i];
            exp_d.delete();
            v = cur;
            while (v != clamped) begin
                if (clamped > v) v = (v + cs > clamped) ? clamped : v + cs;
                else             v = (v - cs < clamped) ? clamped : v - cs;
                exp_d.push_back(v);
            end
            total++; if (timed_out) begin bad++; $display("FAIL row%0d timeout got=%0d want=0", i, timed_out); end
            total++; if (st_duty.size() != exp_d.size()) begin bad++; $display("FAIL row%0d strobes got=%0d want=%0d", i, st_duty.size(), exp_d.size()); end
            want_done = 0;
            for (int k = 0; k < exp_d.size(); k++) begin
                idx = k * (h[i] + 1) + h[i];
                want_c = (idx < pe_edges.size()) ? pe_edges[idx] : -1;
                if (k == exp_d.size() - 1) want_done = want_c;
                if (k < st_duty.size()) begin
                    total++; if (st_duty[k] != exp_d[k]) begin bad++; $display("FAIL row%0d duty%0d got=%0d want=%0d", i, k, st_duty[k], exp_d[k]); end
                    total++; if (st_cyc[k] != want_c) begin bad++; $display("FAIL row%0d cyc%0d got=%0d want=%0d", i, k, st_cyc[k], want_c); end
                end
            end
            total++; if (done_cnt != 1) begin bad++; $display("FAIL row%0d done_cnt got=%0d want=1", i, done_cnt); end
            total++; if (done_cyc != want_done) begin bad++; $display("FAIL row%0d done_cyc got=%0d want=%0d", i, done_cyc, want_done); end
            total++; if (busy0 != (exp_d.size() != 0)) begin bad++; $display("FAIL row%0d busy0 got=%0d want=%0d", i, busy0, exp_d.size() != 0); end
            total++; if (rdy_early != 0) begin bad++; $display("FAIL row%0d ready_busy got=%0d want=0", i, rdy_early); end
            total++; if (busy_after || !rdy_after) begin bad++; $display("FAIL row%0d after busy=%0d ready=%0d want 0/1", i, busy_after, rdy_after); end
            total++; if (dchg != 0) begin bad++; $display("FAIL row%0d unstrobed_change got=%0d want=0", i, dchg); end
            total++; if (int'(pwm_duty_cycle) != clamped) begin bad++; $display("FAIL row%0d final got=%0d want=%0d", i, pwm_duty_cycle, clamped); end
            cur = clamped;
        end
    endtask

    task automatic test_reset_midramp();
        bit reached;
        do_ramp(0, 15, 0, 1'b0, 1'b0, 0, 0, 0);
        cur = 0;
        cmd_valid = 1'b1; cmd_target = DW'(8); cmd_step = DW'(2); cmd_hold = '0; period_end = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        reached = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            period_end = (c % 3 == 2);
            @(posedge clk); #1;
            if (int'(pwm_duty_cycle) == 4) reached = 1;
        end
        period_end = 1'b0;
        total++; if (!reached) begin bad++; $display("FAIL mid_reach got=%0d want=4", pwm_duty_cycle); end
        #3 reset = 1'b1;
        #1;
        total++; if (int'(pwm_duty_cycle) !== INITD) begin bad++; $display("FAIL mid_duty got=%0d want=%0d", pwm_duty_cycle, INITD); end
        total++; if (update_parameters !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_flags upd=%b busy=%b done=%b want 0/0/0", update_parameters, busy, done);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", cmd_ready); end
        cur = INITD;
        do_ramp(5, 1, 0, 1'b0, 1'b0, 0, 0, 0);
        total++; if (timed_out || st_duty.size() != 5) begin bad++; $display("FAIL mid_ramp strobes got=%0d want=5", st_duty.size()); end
        total++; if (int'(pwm_duty_cycle) != 5) begin bad++; $display("FAIL mid_final got=%0d want=5", pwm_duty_cycle); end
        cur = 5;
    endtask

    initial begin
        test_reset();
        test_ramps();
        test_reset_midramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
- Sequencer that drives a PWMGenerator's pwm_duty_cycle/update_parameters inputs and ramps the duty from its current value to a commanded target.
- Steps by a programmable increment every N PWM periods, paced by the generator's period_end.
- Sits between a host/command source and one PWMGenerator instance; used for soft-start, fades and motor ramps.

Parameters:
- DUTY_WIDTH, 4, width of duty/target/step fields; matches the PWMGenerator duty port.
- MAX_DUTY, 8, largest legal duty (equals the generator period); targets above it are clamped.
- INITIAL_DUTY, 0, duty driven out of reset; must equal the generator's INITIAL_DUTY.
- HOLD_WIDTH, 8, width of the periods-per-step field.

Ports:
- clk  input  1  single system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready on a rising clk edge.
- cmd_target  input  DUTY_WIDTH  final duty.
- cmd_step  input  DUTY_WIDTH  duty change per step; 0 is treated as 1.
- cmd_hold  input  HOLD_WIDTH  extra periods between steps; 0 means a step every period.
- period_end  input  1  one-cycle pulse from the generator at the end of each period.
- pwm_duty_cycle  output  DUTY_WIDTH  duty to the generator.
- update_parameters  output  1  one-cycle latch strobe to the generator.
- busy  output  1  ramp in progress.
- done  output  1  one-cycle pulse when the target is reached or the command is a no-op.

Behaviour:
- Reset (async):
  - state=IDLE, pwm_duty_cycle=INITIAL_DUTY.
  - update_parameters=0, done=0, busy=0, cmd_ready=1 on release.
  - Hold counter and latched command are cleared.
- All outputs are registered.
- States: IDLE, RAMP, FINISH.
- IDLE:
  - cmd_ready=1; period_end is ignored.
  - On accept, latch tgt=min(cmd_target, MAX_DUTY), step=max(cmd_step, 1), hold=cmd_hold, and load hold_cnt=cmd_hold.
  - If tgt==pwm_duty_cycle, go to FINISH and emit no update strobe.
  - Otherwise go to RAMP with busy=1 from the next cycle.
- RAMP:
  - cmd_ready=0. A period_end in the same cycle as acceptance does not count; pacing starts at the first period_end after entry.
  - On a period_end with hold_cnt!=0: hold_cnt decrements.
  - On a period_end with hold_cnt==0:
    - Next cycle, pwm_duty_cycle moves toward tgt by step, saturating at tgt with no overshoot.
    - update_parameters pulses for exactly that cycle; hold_cnt reloads to hold.
  - If the new duty equals tgt, done pulses in the same cycle as that final update_parameters, then go to IDLE (busy drops the cycle after).
- FINISH: done=1 for one cycle, then IDLE; used only for the no-op case.
- Latency: strobe is 1 cycle after the qualifying period_end. The generator applies the value at its next period boundary, so the first changed period starts (hold+1) periods after the command.
- Arithmetic: up/down direction compared at width DUTY_WIDTH+1 to avoid wrap. Down-step saturates at tgt and never underflows below 0; up-step never exceeds MAX_DUTY.
- pwm_duty_cycle is stable between strobes. update_parameters is never asserted on two consecutive cycles.
- cmd_valid while busy is held off by cmd_ready=0; no command is dropped or queued.
- Reset mid-ramp returns to INITIAL_DUTY immediately, with no strobe. The integrator resets the generator with the same reset.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - state enum typedef (IDLE, RAMP, FINISH);
  - the duty_t typedef sized by DUTY_WIDTH;
  - a saturating step function (current, target, step -> next).
- One sub-module, pwm_period_pacer: hold_cnt down-counter with load, period_end decrement and a "step_now" output. It is reusable by later PWM sequencers.
- FSM and duty register stay in the top.

Test Plan:
- Up-ramp: INITIAL_DUTY=0, target=8, step=2, hold=0 -> strobes 1 cycle after each of the next 4 period_ends with duty 2,4,6,8; done with the 4th strobe; the generator's measured duty per period matches the previous strobe.
- Down-ramp with saturation: from 8, target=1, step=3, hold=1 -> strobes every 2nd period_end, duty 5,2,1; done on the value 1; no underflow.
- No-op and clamp: target == current duty -> done 1 cycle after accept, no update_parameters, busy stays 0. Target=15 with MAX_DUTY=8 -> final duty 8.
- Handshake: cmd_valid held high during a ramp -> cmd_ready=0 throughout; the second command is accepted in the cycle after the first done returns to IDLE; period_end coincident with accept is not counted.
- step=0, hold=0, target=3 from 0 -> three strobes with duty 1,2,3.
- Reset asserted mid-ramp at duty 4 -> outputs return to INITIAL_DUTY/0 asynchronously; after release cmd_ready=1 and a new ramp proceeds normally.
